// File: rtl/mult_div_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: funct codes,
// FSM state encodings, iteration bound and a conditional-negate helper.
package mult_div_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned FUNCT_W = 6;

    localparam logic [FUNCT_W-1:0] FUNCT_MFHI  = 6'h10;
    localparam logic [FUNCT_W-1:0] FUNCT_MTHI  = 6'h11;
    localparam logic [FUNCT_W-1:0] FUNCT_MFLO  = 6'h12;
    localparam logic [FUNCT_W-1:0] FUNCT_MTLO  = 6'h13;
    localparam logic [FUNCT_W-1:0] FUNCT_MULT  = 6'h18;
    localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'h19;
    localparam logic [FUNCT_W-1:0] FUNCT_DIV   = 6'h1A;
    localparam logic [FUNCT_W-1:0] FUNCT_DIVU  = 6'h1B;

    // Counter value of the 32nd (final) iteration.
    localparam logic [4:0] MD_ITER_LAST = 5'd31;

    typedef enum logic [1:0] {
        MD_STATE_IDLE = 2'd0,
        MD_STATE_BUSY = 2'd1,
        MD_STATE_DONE = 2'd2
    } md_state_t;

    function automatic logic [DATA_W-1:0] neg_if(input logic c, input logic [DATA_W-1:0] v);
        return c ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mult_div_if.sv
// EX-stage connection between the pipeline and the multiply/divide unit.
interface mult_div_if;
    import mult_div_pkg::*;

    // en marks a valid instruction in EX; while stall_req is high the
    // pipeline holds en/funct/operands stable, and the instruction retires
    // on the first rising edge where stall_req is low.
    logic                 en;
    logic [FUNCT_W-1:0]   funct;
    logic [DATA_W-1:0]    operand_1;
    logic [DATA_W-1:0]    operand_2;
    logic                 flush;
    logic                 stall_req;
    logic [DATA_W-1:0]    result;
    logic [DATA_W-1:0]    hi;
    logic [DATA_W-1:0]    lo;
    md_state_t            state;

    modport master (
        output en, funct, operand_1, operand_2, flush,
        input  stall_req, result, hi, lo, state
    );

    modport slave (
        input  en, funct, operand_1, operand_2, flush,
        output stall_req, result, hi, lo, state
    );

endinterface

// File: rtl/mult_div_div_core.sv
// Restoring divider datapath: partial remainder and quotient shift register,
// one quotient bit per step on unsigned magnitudes.
module div_core
    import mult_div_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] quo_nxt,
    output logic [DATA_W-1:0] rem_nxt,
    output logic              div_zero
);

    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] dvs_q;
    logic [DATA_W:0]   shifted;
    logic [DATA_W+1:0] diff;

    // A non-negative trial difference always fits in 32 bits, so bits 33:32
    // both being zero is the "subtract succeeds" condition.
    always_comb begin
        shifted = {rem_q, quo_q[DATA_W-1]};
        diff    = {1'b0, shifted} - {2'b00, dvs_q};
        if (diff[DATA_W+1:DATA_W] == 2'b00) begin
            rem_nxt = diff[DATA_W-1:0];
            quo_nxt = {quo_q[DATA_W-2:0], 1'b1};
        end else begin
            rem_nxt = shifted[DATA_W-1:0];
            quo_nxt = {quo_q[DATA_W-2:0], 1'b0};
        end
    end

    assign div_zero = (dvs_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (step) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
        end
    end

endmodule

// File: rtl/mult_div.sv
// Iterative MULT/DIV unit owning HI/LO; stalls EX for 33 cycles per op.
// Define MULT_DIV_FAST_MULT_EN for a single-cycle, non-stalling multiply.
module mult_div
    import mult_div_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    mult_div_if.slave  bus
);

    md_state_t         state;
    logic [4:0]        cnt;
    logic              is_div;
    logic              neg_q;
    logic              neg_r;
    logic [DATA_W-1:0] mcand;
    logic [63:0]       mul_acc;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    logic              op_signed;
    logic              a_neg;
    logic              b_neg;
    logic              iter_op;
    logic              start;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    logic [DATA_W:0]   mul_sum;
    logic [63:0]       mul_nxt;
    logic [63:0]       prod_fix;
    logic [DATA_W-1:0] quo_nxt;
    logic [DATA_W-1:0] rem_nxt;
    logic [DATA_W-1:0] quo_fix;
    logic [DATA_W-1:0] rem_fix;
    logic              div_zero;

    always_comb begin
        op_signed = (bus.funct == FUNCT_MULT) || (bus.funct == FUNCT_DIV);
        a_neg     = op_signed & bus.operand_1[DATA_W-1];
        b_neg     = op_signed & bus.operand_2[DATA_W-1];
        a_mag     = neg_if(a_neg, bus.operand_1);
        b_mag     = neg_if(b_neg, bus.operand_2);
    end

`ifdef MULT_DIV_FAST_MULT_EN
    logic [63:0] fast_prod;
    assign fast_prod = {{32{a_neg}}, bus.operand_1} * {{32{b_neg}}, bus.operand_2};
    assign iter_op   = (bus.funct == FUNCT_DIV) || (bus.funct == FUNCT_DIVU);
`else
    assign iter_op   = (bus.funct == FUNCT_DIV) || (bus.funct == FUNCT_DIVU) ||
                       (bus.funct == FUNCT_MULT) || (bus.funct == FUNCT_MULTU);
`endif

    assign start = bus.en && iter_op && !bus.flush;

    // Shift-add step: conditionally add the multiplicand into the upper half,
    // then shift the whole accumulator right, consuming one multiplier bit.
    always_comb begin
        mul_sum  = {1'b0, mul_acc[63:32]} + (mul_acc[0] ? {1'b0, mcand} : 33'd0);
        mul_nxt  = {mul_sum, mul_acc[31:1]};
        prod_fix = neg_q ? (~mul_nxt + 64'd1) : mul_nxt;
        quo_fix  = div_zero ? '1 : neg_if(neg_q, quo_nxt);
        rem_fix  = neg_if(neg_r, rem_nxt);
    end

    div_core u_div_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     ((state == MD_STATE_IDLE) && start),
        .step     ((state == MD_STATE_BUSY) && is_div && !bus.flush),
        .dividend (a_mag),
        .divisor  (b_mag),
        .quo_nxt  (quo_nxt),
        .rem_nxt  (rem_nxt),
        .div_zero (div_zero)
    );

    assign bus.stall_req = !bus.flush &&
                           ((state == MD_STATE_BUSY) || ((state == MD_STATE_IDLE) && start));
    assign bus.result    = !bus.en                   ? '0   :
                           (bus.funct == FUNCT_MFHI) ? hi_q :
                           (bus.funct == FUNCT_MFLO) ? lo_q : '0;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.state     = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= MD_STATE_IDLE;
            cnt     <= '0;
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            mcand   <= '0;
            mul_acc <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (bus.flush) begin
            state <= MD_STATE_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                MD_STATE_IDLE: begin
                    if (bus.en) begin
                        case (bus.funct)
                            FUNCT_MTHI: hi_q <= bus.operand_1;
                            FUNCT_MTLO: lo_q <= bus.operand_1;
`ifdef MULT_DIV_FAST_MULT_EN
                            FUNCT_MULT, FUNCT_MULTU: begin
                                hi_q <= fast_prod[63:32];
                                lo_q <= fast_prod[31:0];
                            end
`endif
                            default: begin
                                if (iter_op) begin
                                    state   <= MD_STATE_BUSY;
                                    cnt     <= '0;
                                    is_div  <= bus.funct[1];
                                    neg_q   <= a_neg ^ b_neg;
                                    neg_r   <= a_neg;
                                    mcand   <= a_mag;
                                    mul_acc <= {32'd0, b_mag};
                                end
                            end
                        endcase
                    end
                end
                MD_STATE_BUSY: begin
                    cnt     <= cnt + 5'd1;
                    mul_acc <= mul_nxt;
                    if (cnt == MD_ITER_LAST) begin
                        state <= MD_STATE_DONE;
                        if (is_div) begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end else begin
                            hi_q <= prod_fix[63:32];
                            lo_q <= prod_fix[31:0];
                        end
                    end
                end
                default: state <= MD_STATE_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div.sv
// Directed plus randomized checks of mult_div: HI/LO moves, iterative
// multiply/divide results and stall length, flush and reset mid-operation.
module tb_mult_div;
    import mult_div_pkg::*;

`ifdef MULT_DIV_FAST_MULT_EN
    localparam int MUL_STALLS = 0;
`else
    localparam int MUL_STALLS = 33;
`endif
    localparam int DIV_STALLS = 33;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mult_div_if bus ();

    mult_div dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] cur_hi = '0;
    logic [31:0] cur_lo = '0;

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        exp = exp_q.pop_front();
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.en        = 1'b1;
        bus.funct     = f;
        bus.operand_1 = a;
        bus.operand_2 = b;
    endtask

    // Issues one instruction, holds it while stalled, retires it, then
    // compares stall length and the resulting HI/LO.
    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int exp_stall,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int stalls;
        exp_q.push_back(32'(exp_stall));
        exp_q.push_back(exp_hi);
        exp_q.push_back(exp_lo);
        cur_hi = exp_hi;
        cur_lo = exp_lo;
        drive(f, a, b);
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.stall_req) break;
            stalls++;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        bus.en    = 1'b0;
        bus.funct = '0;
        check({tag, " stall"}, 32'(stalls));
        check({tag, " hi"}, bus.hi);
        check({tag, " lo"}, bus.lo);
    endtask

    task automatic run_divu(input string tag, input logic [31:0] a, input logic [31:0] b);
        if (b == 0) run_op(tag, FUNCT_DIVU, a, b, DIV_STALLS, a, 32'hFFFF_FFFF);
        else        run_op(tag, FUNCT_DIVU, a, b, DIV_STALLS, a % b, a / b);
    endtask

    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, q, r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        q  = sa / sb;
        r  = sa % sb;
        run_op(tag, FUNCT_DIV, a, b, DIV_STALLS, r[31:0], q[31:0]);
    endtask

    task automatic run_mult(input string tag, input logic is_signed, input logic [31:0] a,
                            input logic [31:0] b);
        logic [63:0] p;
        p = {{32{is_signed & a[31]}}, a} * {{32{is_signed & b[31]}}, b};
        run_op(tag, is_signed ? FUNCT_MULT : FUNCT_MULTU, a, b, MUL_STALLS, p[63:32], p[31:0]);
    endtask

    initial begin
        logic [31:0] ra, rb;
        rst_n         = 1'b0;
        bus.en        = 1'b0;
        bus.funct     = '0;
        bus.operand_1 = '0;
        bus.operand_2 = '0;
        bus.flush     = 1'b0;

        #12;
        repeat (5) exp_q.push_back(32'd0);
        check("reset stall", {31'd0, bus.stall_req});
        check("reset result", bus.result);
        check("reset hi", bus.hi);
        check("reset lo", bus.lo);
        check("reset state", {30'd0, bus.state});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("mthi", FUNCT_MTHI, 32'h1234_5678, 32'h0, 0, 32'h1234_5678, 32'h0);
        exp_q.push_back(32'h1234_5678);
        exp_q.push_back(32'd0);
        drive(FUNCT_MFHI, 32'h0, 32'h0);
        @(negedge clk);
        check("mfhi result", bus.result);
        check("mfhi stall", {31'd0, bus.stall_req});
        @(posedge clk);
        #1;
        run_op("mtlo", FUNCT_MTLO, 32'hCAFE_F00D, 32'h0, 0, 32'h1234_5678, 32'hCAFE_F00D);
        exp_q.push_back(32'hCAFE_F00D);
        drive(FUNCT_MFLO, 32'h0, 32'h0);
        @(negedge clk);
        check("mflo result", bus.result);
        @(posedge clk);
        #1;
        bus.en = 1'b0;

        run_divu("divu 100/7", 32'd100, 32'd7);
        exp_q.push_back(32'(MD_STATE_IDLE));
        check("state after done", {30'd0, bus.state});
        run_div("div -7/2", 32'hFFFF_FFF9, 32'd2);
        run_mult("mult -1*-1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_mult("multu ff*ff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_divu("divu 5/0", 32'd5, 32'd0);
        run_div("div 7/-2", 32'd7, 32'hFFFF_FFFE);

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom_range(1, 100000);
            run_divu("rand divu", ra, rb);
            rb = $urandom_range(1, 300);
            if ($urandom_range(0, 1) == 1) rb = ~rb + 32'd1;
            if (ra == 32'h8000_0000) ra = 32'd1;
            run_div("rand div", ra, rb);
            run_mult("rand mult", 1'b1, $urandom, $urandom);
            run_mult("rand multu", 1'b0, $urandom, $urandom);
        end

        // Flush ten cycles into a divide: no stall that cycle, HI/LO kept.
        drive(FUNCT_DIVU, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        exp_q.push_back(32'd0);
        @(negedge clk);
        check("flush stall", {31'd0, bus.stall_req});
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.en    = 1'b0;
        exp_q.push_back(32'(MD_STATE_IDLE));
        exp_q.push_back(cur_hi);
        exp_q.push_back(cur_lo);
        exp_q.push_back(32'd0);
        check("flush state", {30'd0, bus.state});
        check("flush hi", bus.hi);
        check("flush lo", bus.lo);
        @(negedge clk);
        check("post flush stall", {31'd0, bus.stall_req});

        // Reset ten cycles into a divide clears HI/LO immediately.
        @(posedge clk);
        #1;
        drive(FUNCT_DIVU, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        rst_n  = 1'b0;
        bus.en = 1'b0;
        #1;
        repeat (4) exp_q.push_back(32'd0);
        check("rst mid hi", bus.hi);
        check("rst mid lo", bus.lo);
        check("rst mid state", {30'd0, bus.state});
        check("rst mid stall", {31'd0, bus.stall_req});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_divu("divu after reset", 32'd100, 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
